// File: rtl/fft_in_addr_gen.sv
// Read-address generator that streams 2*filesize interleaved re/im words into the FFT input buffer.
// It issues requests with a bounded number of reads in flight, then waits for all data before pulsing done.
module fft_in_addr_gen #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] filesize,
  input  logic        abort,
  input  logic        rd_ready,
  input  logic        rd_data_valid,
  output logic        rd_valid,
  output logic [31:0] rd_addr,
  output logic [31:0] count,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] total_q, total_d;
  logic [31:0] count_q, count_d;
  logic [31:0] returned_q, returned_d;
  logic [3:0]  outstanding_q, outstanding_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        acc;
  logic        ret;
  logic [31:0] total_in;

  assign total_in = filesize << 1;

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    total_d       = total_q;
    count_d       = count_q;
    returned_d    = returned_q;
    outstanding_d = outstanding_q;

    // rd_valid_q is only ever high in ISSUE, so a handshake implies ISSUE.
    acc = rd_valid_q & rd_ready;
    ret = rd_data_valid & ((state_q == ISSUE) | (state_q == WAIT)) &
          (returned_q != total_q);

    if (acc) begin
      count_d = count_q + 32'd1;
    end
    if (ret) begin
      returned_d = returned_q + 32'd1;
    end
    unique case ({acc, ret})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            base_d        = base_addr;
            total_d       = total_in;
            count_d       = 32'd0;
            returned_d    = 32'd0;
            outstanding_d = 4'd0;
            state_d       = (total_in == 32'd0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (acc && (count_d == total_q)) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (returned_d == total_q) begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are computed from next state so they are registered yet current.
    rd_valid_d = (state_d == ISSUE) && (outstanding_d < MAX_OUT);
    rd_addr_d  = (state_d == ISSUE) ? (base_d + count_d) : rd_addr_q;
    busy_d     = (state_d == ISSUE) || (state_d == WAIT);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      base_q        <= 32'd0;
      total_q       <= 32'd0;
      count_q       <= 32'd0;
      returned_q    <= 32'd0;
      outstanding_q <= 4'd0;
      rd_valid_q    <= 1'b0;
      rd_addr_q     <= 32'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      total_q       <= total_d;
      count_q       <= count_d;
      returned_q    <= returned_d;
      outstanding_q <= outstanding_d;
      rd_valid_q    <= rd_valid_d;
      rd_addr_q     <= rd_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_addr  = rd_addr_q;
  assign count    = count_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fft_in_addr_gen.sv
// Bench for fft_in_addr_gen: scenario table, hand-written corner sequences and randomized
// transfers checked against a transaction-level model (accepted/returned counts, address list).
module tb_fft_in_addr_gen;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [31:0] filesize = 32'd0;
  logic        abort = 1'b0;
  logic        rd_ready = 1'b0;
  logic        rd_data_valid = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_addr;
  logic [31:0] count;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] acc_q[$];
  int          done_cnt;

  fft_in_addr_gen #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .filesize(filesize),
    .abort(abort), .rd_ready(rd_ready), .rd_data_valid(rd_data_valid),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [31:0] fs;
    int          lat;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_n;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: the bench tracks accepted and returned words itself and derives
  // every expected output from those counts and the transfer length.
  task automatic run_xfer(input logic [31:0] b, input logic [31:0] fs,
                          input int rdy_pct, input int lat);
    logic [31:0] total, nacc, nret;
    int          due[$];
    int          cyc, l;
    bit          exp_active, exp_done, exp_rdv, done_seen, finished;
    total = fs << 1;
    acc_q.delete();
    done_cnt = 0;
    nacc = 0;
    nret = 0;
    done_seen = 0;
    finished = 0;
    abort = 0;
    rd_ready = 0;
    rd_data_valid = 0;
    base_addr = b;
    filesize = fs;
    start = 1;
    tick();
    start = 0;
    for (cyc = 0; cyc < 2000; cyc++) begin
      exp_active = (nret != total);
      exp_done   = !exp_active && !done_seen;
      exp_rdv    = exp_active && (nacc != total) && ((nacc - nret) < MAX);
      chk("busy", busy, exp_active);
      chk("done", done, exp_done);
      chk("rd_valid", rd_valid, exp_rdv);
      chk("count", count, nacc);
      if (rd_valid) chk("rd_addr", rd_addr, b + nacc);
      if (done) done_cnt++;
      if (done_seen) begin
        finished = 1;
        break;
      end
      if (exp_done) done_seen = 1;
      rd_ready = ($urandom_range(99) < rdy_pct);
      rd_data_valid = 0;
      if (due.size() > 0 && due[0] <= cyc) begin
        rd_data_valid = 1;
        void'(due.pop_front());
        nret++;
      end
      if (rd_valid && rd_ready) begin
        acc_q.push_back(rd_addr);
        nacc++;
        l = (lat < 0) ? $urandom_range(1, 6) : lat;
        due.push_back(cyc + l);
      end
      tick();
    end
    chk("xfer_finished", {31'd0, finished}, 32'd1);
    rd_ready = 0;
    rd_data_valid = 0;
  endtask

  vec_t vecs[6];

  initial begin
    int rdy_pat[4];
    logic [31:0] exp_cnt[4];
    logic [31:0] exp_adr[4];
    logic [31:0] rb, rf;

    vecs[0] = '{32'h0000_0100, 32'd3,          2, 32'h0000_0100, 32'h0000_0105, 6};
    vecs[1] = '{32'hFFFF_FFFE, 32'd2,          1, 32'hFFFF_FFFE, 32'h0000_0001, 4};
    vecs[2] = '{32'h0000_0000, 32'd0,          2, 32'h0,         32'h0,         0};
    vecs[3] = '{32'h0000_0ABC, 32'd1,          5, 32'h0000_0ABC, 32'h0000_0ABD, 2};
    vecs[4] = '{32'h7FFF_FFF0, 32'd8,          3, 32'h7FFF_FFF0, 32'h7FFF_FFFF, 16};
    vecs[5] = '{32'h0000_0040, 32'h8000_0001,  1, 32'h0000_0040, 32'h0000_0041, 2};

    // Asynchronous reset with no clock edge in between.
    #2 rst = 1;
    #2;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i].base, vecs[i].fs, 100, vecs[i].lat);
      chk("tbl_n_acc", acc_q.size(), vecs[i].exp_n);
      if (vecs[i].exp_n > 0) begin
        chk("tbl_first_addr", acc_q[0], vecs[i].exp_first);
        chk("tbl_last_addr", acc_q[acc_q.size()-1], vecs[i].exp_last);
      end
      chk("tbl_done_pulses", done_cnt, 1);
    end

    // Outstanding limit: no returns caps acceptances at MAX; one return frees one slot.
    base_addr = 32'h500; filesize = 32'd4; start = 1;
    tick();
    start = 0; rd_ready = 1;
    repeat (6) tick();
    chk("lim_count4", count, 4);
    chk("lim_rdv_low", rd_valid, 0);
    chk("lim_busy", busy, 1);
    rd_data_valid = 1;
    tick();
    rd_data_valid = 0;
    chk("lim_rdv_again", rd_valid, 1);
    chk("lim_addr", rd_addr, 32'h504);
    tick();
    chk("lim_count5", count, 5);
    chk("lim_rdv_low2", rd_valid, 0);
    repeat (3) tick();
    chk("lim_count5_hold", count, 5);
    rd_ready = 0; abort = 1;
    tick();
    abort = 0;
    chk("lim_abort_busy", busy, 0);
    chk("lim_abort_rdv", rd_valid, 0);

    // Stall: address holds while rd_ready is low; count moves only on handshakes.
    rdy_pat = '{1, 0, 0, 1};
    exp_cnt = '{32'd1, 32'd1, 32'd1, 32'd2};
    exp_adr = '{32'h2001, 32'h2001, 32'h2001, 32'h2002};
    base_addr = 32'h2000; filesize = 32'd2; start = 1;
    tick();
    start = 0;
    chk("stall_addr0", rd_addr, 32'h2000);
    chk("stall_cnt0", count, 0);
    for (int i = 0; i < 4; i++) begin
      rd_ready = rdy_pat[i][0];
      tick();
      chk("stall_cnt", count, exp_cnt[i]);
      chk("stall_addr", rd_addr, exp_adr[i]);
      chk("stall_rdv", rd_valid, 1);
    end
    rd_ready = 0; abort = 1;
    tick();
    abort = 0;

    // Abort in WAIT with two reads outstanding, with start asserted alongside.
    base_addr = 32'h600; filesize = 32'd1; start = 1;
    tick();
    start = 0; rd_ready = 1;
    repeat (2) tick();
    rd_ready = 0;
    chk("wait_busy", busy, 1);
    chk("wait_rdv", rd_valid, 0);
    chk("wait_count", count, 2);
    abort = 1; start = 1;
    tick();
    abort = 0; start = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rdv", rd_valid, 0);
    tick();
    chk("abort_done2", done, 0);
    chk("abort_count_hold", count, 2);
    run_xfer(32'h700, 32'd2, 100, 3);
    chk("post_abort_n", acc_q.size(), 4);
    chk("post_abort_done", done_cnt, 1);

    // Abort beats completion when the last word returns in the same cycle.
    base_addr = 32'h800; filesize = 32'd1; start = 1;
    tick();
    start = 0; rd_ready = 1;
    repeat (2) tick();
    rd_ready = 0; rd_data_valid = 1;
    tick();
    abort = 1;
    tick();
    abort = 0; rd_data_valid = 0;
    chk("abort_vs_done", done, 0);
    chk("abort_vs_busy", busy, 0);
    tick();
    chk("abort_vs_done2", done, 0);

    // Reset in the middle of ISSUE clears outputs without a clock edge.
    base_addr = 32'h900; filesize = 32'd8; start = 1;
    tick();
    start = 0; rd_ready = 1;
    repeat (3) tick();
    chk("mid_busy", busy, 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_rdv", rd_valid, 0);
    chk("mid_rst_addr", rd_addr, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    rd_ready = 0;
    @(negedge clk);
    rst = 0;
    run_xfer(32'h40, 32'd1, 100, 1);
    chk("post_rst_n", acc_q.size(), 2);
    chk("post_rst_done", done_cnt, 1);

    // Randomized transfers with random ready and random return latency.
    for (int t = 0; t < 20; t++) begin
      rb = $urandom;
      rf = $urandom_range(1, 6);
      run_xfer(rb, rf, $urandom_range(30, 100), -1);
      chk("rnd_n_acc", acc_q.size(), rf << 1);
      chk("rnd_first", acc_q[0], rb);
      chk("rnd_done_pulses", done_cnt, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
